spi_result_bridge: RTL and testbench
====================================

// Module: spi_result_bridge
// PURPOSE
//  SPI mode-0 slave front end between the host and the matmul accelerator core.
//  - Deserialises host MOSI words into single-cycle write pulses for the core.
//  - Buffers up to RES_DEPTH core results in a FIFO; the host reads them back over MISO.
//  - Generalises the single 32-bit result/done readout to a multi-word, parametrised, readable result path.
// PARAMETERS
//  DATA_W     32  width of each host->core write word (multiple of 8)
//  RES_W      32  width of each result word (multiple of 8)
//  RES_DEPTH  4   result FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1        system clock; SPI sampled in this domain
//  rst          in   1        synchronous, active-high reset
//  spi_sclk     in   1        SPI clock (asynchronous, < clk/4)
//  spi_mosi     in   1        SPI data in, MSB first
//  spi_cs_n     in   1        SPI chip select, active low
//  spi_miso     out  1        SPI data out, MSB first
//  wr_valid     out  1        one-cycle pulse: wr_data holds a complete host word
//  wr_data      out  DATA_W   host word, held until next wr_valid
//  res_valid    in   1        core pushes res_data this cycle
//  res_data     in   RES_W    result word from core
//  matmul_done  in   1        core completion pulse
//  res_avail    out  1        FIFO non-empty (host interrupt)
// BEHAVIOUR
//  Reset values: spi_miso=0, wr_valid=0, wr_data=0, res_avail=0.
//  Reset clears FIFO, flags, FSM, and all shift registers.
//  Sync: sclk, cs_n, mosi each 2-FF synchronised; sclk edges detected on registered copies.
//  - MOSI sampled on the detected sclk rise.
//  - MISO updated on the detected sclk fall.
//  Frame = cs_n low..high. First byte is the command: 0x01 WRITE, 0x02 READ, 0x03 STATUS.
//  FSM states:
//  - IDLE -> CMD on cs_n fall.
//  - CMD -> WRITE/READ/STATUS after 8th bit; any other code -> IGNORE.
//  - Any state -> IDLE on cs_n rise.
//  WRITE:
//  - Every DATA_W bits, wr_valid pulses 3 clk after the raw sclk rise of the last bit; repeats until cs_n high.
//  READ:
//  - At the command's 8th bit, the FIFO head is popped into the MISO shift register; first bit is driven on the next sclk fall.
//  - Each further RES_W bits pops the next word.
//  - Pop on empty shifts out 0 and does not change pointers.
//  STATUS:
//  - Returns one byte {done, overflow, 2'b0, count[3:0]}; count saturates at 15.
//  - done and overflow clear at the end of the status byte.
//  IGNORE: MISO=0, no side effects.
//  FIFO:
//  - Push on res_valid when not full.
//  - Push when full drops the word and sets sticky overflow.
//  - Same-cycle push+pop is legal at any occupancy, including full; count is unchanged.
//  - Pointers wrap mod RES_DEPTH.
//  done: sticky, set by matmul_done. Simultaneous set and clear -> set wins.
//  cs_n rise mid-word: partial word discarded; no wr_valid, no pop.
//  Reset mid-frame: bridge stays in IDLE until cs_n is observed high, then accepts the next frame.
// CONFIGURATION
//  SPI_BRIDGE_ECHO_EN defined:
//  - Command 0x04 ECHO: MISO returns each received byte one byte later; the first byte returned is 0x00.
//  - Used for link bring-up.
//  Undefined: 0x04 is an unknown command and goes to IGNORE.
// STRUCTURE
//  spi_bridge_pkg:
//  - bridge_cmd_e (CMD_WRITE/READ/STATUS/ECHO)
//  - bridge_state_e (IDLE, CMD, WRITE, READ, STATUS, IGNORE, ECHO)
//  - STATUS bit positions
//  Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall detect for sclk, with plain sync for cs_n and mosi.
//  FIFO inline: array, wrap pointers, count.
// TESTING
//  1 WRITE 0x01 then 0xDEADBEEF, 0x01234567 -> two wr_valid pulses with those values; nothing after cs_n rise.
//  2 Push 0xAAAA0001..0xAAAA0003, then READ 96 bits -> MISO returns the three words in order; res_avail drops after the 3rd pop.
//  3 Push 5 words, RES_DEPTH=4, matmul_done -> STATUS byte 0xC4; a second STATUS returns 0x04.
//  4 READ on empty FIFO -> MISO all zeros; a following STATUS shows count 0.
//  5 cs_n rise after 20 bits of a WRITE word, and separately rst mid-READ -> no wr_valid, no pop; the next full frame works.
//  6 Push and pop in the same clk while full -> count stays 4, data order preserved; ECHO_EN build: 0x04 0x5A 0x3C -> MISO 0x00 0x5A.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: command codes, FSM states and STATUS byte layout
// shared by the SPI result bridge files.
package spi_bridge_pkg;

  typedef enum logic [7:0] {
    CMD_WRITE  = 8'h01,
    CMD_READ   = 8'h02,
    CMD_STATUS = 8'h03,
    CMD_ECHO   = 8'h04
  } bridge_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    STATUS,
    IGNORE,
    ECHO
  } bridge_state_e;

  localparam int STAT_DONE    = 7;
  localparam int STAT_OVF     = 6;
  localparam int STAT_CNT_LSB = 0;

  function automatic logic [7:0] status_byte(
    input logic       done,
    input logic       ovf,
    input logic [3:0] cnt
  );
    logic [7:0] b;
    b = '0;
    b[STAT_DONE] = done;
    b[STAT_OVF] = ovf;
    b[STAT_CNT_LSB +: 4] = cnt;
    return b;
  endfunction

endpackage

// File: rtl/spi_result_bridge_if.sv
// spi_result_bridge_if: core-side bus of the bridge
// (host write pulses out, result pushes in, completion and interrupt).
interface spi_result_bridge_if #(
  parameter int DATA_W = 32,
  parameter int RES_W  = 32
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic              matmul_done;
  logic              res_avail;

  modport master (
    output wr_valid, wr_data, res_avail,
    input  res_valid, res_data, matmul_done
  );

  modport slave (
    input  wr_valid, wr_data, res_avail,
    output res_valid, res_data, matmul_done
  );
endinterface

// File: rtl/spi_result_bridge_sync.sv
// spi_sync_edge: 2-FF synchronisers for the SPI pins and
// sclk rise/fall detection on a registered copy.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s,
  output logic cs_n_s
);
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] cs_q;

  // synchroniser chains; cleared to 0 so a low cs_n never looks like a fall
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
      cs_q <= {cs_q[0], cs_n};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign mosi_s = mosi_q[1];
  assign cs_n_s = cs_q[1];
endmodule

// File: rtl/spi_result_bridge.sv
// spi_result_bridge: SPI mode-0 slave with host write path and result FIFO.
// Optional SPI_BRIDGE_ECHO_EN adds the 0x04 ECHO link-test command.
module spi_result_bridge
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RES_W     = 32,
  parameter int RES_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_mosi,
  input  logic spi_cs_n,
  output logic spi_miso,
  spi_result_bridge_if.master core
);
  localparam int MAX_W = (DATA_W > RES_W) ? DATA_W : RES_W;
  localparam int CNT_W = $clog2(MAX_W);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;

  bridge_state_e state_q, state_d;

  logic rise, fall, mosi_s, cs_s, cs_d;
  logic cs_fall, cs_rise;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-2:0] rx;
  logic [RES_W-1:0] tx, tx_val;
  logic [7:0] cmd_byte;
  logic cnt_clr, pop_req, load_tx, wr_fire, clr_flags;
  logic done_q, ovf_q;

  logic [RES_W-1:0] mem [RES_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic full, empty, push, pop, ovf_evt;
  logic [RES_W-1:0] head_word;
  logic [31:0] cnt_ext;
  logic [3:0] cnt4;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .cs_n      (spi_cs_n),
    .sclk_rise (rise),
    .sclk_fall (fall),
    .mosi_s    (mosi_s),
    .cs_n_s    (cs_s)
  );

  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign cmd_byte = {rx[6:0], mosi_s};

  assign full = (count == CW'(RES_DEPTH));
  assign empty = (count == '0);
  assign pop = pop_req & ~empty;
  assign push = core.res_valid & (~full | pop);
  assign ovf_evt = core.res_valid & full & ~pop;
  assign head_word = empty ? '0 : mem[rp];
  assign core.res_avail = ~empty;

  // FIFO occupancy reported in 4 bits, saturating at 15
  always_comb begin
    cnt_ext = 32'(count);
    cnt4 = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
  end

  // next state plus per-cycle strobes for the datapath
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    pop_req = 1'b0;
    load_tx = 1'b0;
    tx_val = '0;
    wr_fire = 1'b0;
    clr_flags = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (cs_fall) state_d = CMD;
      end
      CMD: begin
        if (rise && cnt == CNT_W'(7)) begin
          cnt_clr = 1'b1;
          unique case (1'b1)
            (cmd_byte == CMD_WRITE): state_d = WRITE;
            (cmd_byte == CMD_READ): begin
              state_d = READ;
              pop_req = 1'b1;
              load_tx = 1'b1;
              tx_val = head_word;
            end
            (cmd_byte == CMD_STATUS): begin
              state_d = STATUS;
              load_tx = 1'b1;
              tx_val = RES_W'(status_byte(done_q, ovf_q, cnt4)) << (RES_W - 8);
            end
`ifdef SPI_BRIDGE_ECHO_EN
            (cmd_byte == CMD_ECHO): begin
              state_d = ECHO;
              load_tx = 1'b1;
              tx_val = '0;
            end
`endif
            default: state_d = IGNORE;
          endcase
        end
      end
      WRITE: begin
        if (rise && cnt == CNT_W'(DATA_W - 1)) begin
          wr_fire = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      READ: begin
        if (rise && cnt == CNT_W'(RES_W - 1)) begin
          pop_req = 1'b1;
          load_tx = 1'b1;
          tx_val = head_word;
          cnt_clr = 1'b1;
        end
      end
      STATUS: begin
        if (rise && cnt == CNT_W'(7)) begin
          clr_flags = 1'b1;
          cnt_clr = 1'b1;
          state_d = IGNORE;
        end
      end
      ECHO: begin
        if (rise && cnt == CNT_W'(7)) begin
          load_tx = 1'b1;
          tx_val = RES_W'(cmd_byte) << (RES_W - 8);
          cnt_clr = 1'b1;
        end
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase
    if (cs_rise) begin
      state_d = IDLE;
      pop_req = 1'b0;
      load_tx = 1'b0;
      wr_fire = 1'b0;
      clr_flags = 1'b0;
    end
  end

  // state, cs_n history and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cs_d <= 1'b0;
      cnt <= '0;
    end else begin
      state_q <= state_d;
      cs_d <= cs_s;
      if (cnt_clr) cnt <= '0;
      else if (rise) cnt <= cnt + CNT_W'(1);
    end
  end

  // MOSI shift register and host write pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rx <= '0;
      core.wr_valid <= 1'b0;
      core.wr_data <= '0;
    end else begin
      core.wr_valid <= wr_fire;
      if (wr_fire) core.wr_data <= {rx, mosi_s};
      if (state_q == IDLE) rx <= '0;
      else if (rise) rx <= {rx[DATA_W-3:0], mosi_s};
    end
  end

  // MISO shifter: loaded on a rise, shifted out on each fall
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= '0;
      spi_miso <= 1'b0;
    end else if (state_q == IDLE) begin
      tx <= '0;
      spi_miso <= 1'b0;
    end else if (load_tx) begin
      tx <= tx_val;
    end else if (fall) begin
      spi_miso <= tx[RES_W-1];
      tx <= {tx[RES_W-2:0], 1'b0};
    end
  end

  // sticky done/overflow; a new event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (core.matmul_done) done_q <= 1'b1;
      else if (clr_flags) done_q <= 1'b0;
      if (ovf_evt) ovf_q <= 1'b1;
      else if (clr_flags) ovf_q <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= core.res_data;
  end
endmodule

// File: tb/tb_spi_result_bridge.sv
// tb_spi_result_bridge: host SPI driver and core driver with a queue-based
// reference model; monitors compare wr pulses and MISO words against it.
module tb_spi_result_bridge;
  localparam int DW = 32;
  localparam int RW = 32;
  localparam int DEPTH = 4;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  logic miso;

  spi_result_bridge_if #(.DATA_W(DW), .RES_W(RW)) core ();

  spi_result_bridge #(.DATA_W(DW), .RES_W(RW), .RES_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sclk (sclk),
    .spi_mosi (mosi),
    .spi_cs_n (cs_n),
    .spi_miso (miso),
    .core     (core)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  string rd_name[$];
  logic [31:0] obs_rd[$];

  logic [31:0] mq[$];
  bit m_done = 0;
  bit m_ovf = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void m_push(input logic [31:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1;
  endfunction

  function automatic logic [31:0] m_pop();
    if (mq.size() == 0) return 32'h0;
    return mq.pop_front();
  endfunction

  function automatic void expect_rd(input string nm, input logic [31:0] v);
    exp_rd.push_back(v);
    rd_name.push_back(nm);
  endfunction

  // write-pulse monitor
  always @(negedge clk) begin
    if (core.wr_valid === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual=%0h required=none", core.wr_data);
      end else begin
        check("wr_data", core.wr_data, exp_wr.pop_front());
      end
    end
  end

  // MISO word monitor
  always @(negedge clk) begin
    if (obs_rd.size() > 0) begin
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%0h required=none", obs_rd.pop_front());
      end else begin
        check(rd_name.pop_front(), obs_rd.pop_front(), exp_rd.pop_front());
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic core_push(input logic [31:0] d);
    core.res_data = d;
    core.res_valid = 1'b1;
    hold(1);
    core.res_valid = 1'b0;
    m_push(d);
  endtask

  task automatic core_done();
    core.matmul_done = 1'b1;
    hold(1);
    core.matmul_done = 1'b0;
    m_done = 1;
  endtask

  task automatic xfer(input logic [31:0] d, input int n, input int push_bit,
                      input logic [31:0] pd, output logic [31:0] q);
    q = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      hold(H);
      q = {q[30:0], miso};
      sclk = 1'b1;
      if (i == push_bit) begin
        hold(2);
        core.res_data = pd;
        core.res_valid = 1'b1;
        hold(1);
        core.res_valid = 1'b0;
        hold(H - 3);
      end else begin
        hold(H);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    hold(8);
  endtask

  task automatic frame_end();
    hold(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    hold(10);
  endtask

  task automatic write_frame(input int n, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] q;
    frame_start();
    xfer(32'h01, 8, -1, 0, q);
    for (int k = 0; k < n; k++) begin
      exp_wr.push_back(k == 0 ? w0 : w1);
      xfer(k == 0 ? w0 : w1, 32, -1, 0, q);
    end
    frame_end();
  endtask

  task automatic read_frame(input int n, input bit push_cmd, input logic [31:0] pd);
    logic [31:0] q;
    logic [31:0] first;
    first = m_pop();
    if (push_cmd) m_push(pd);
    expect_rd("cmd_miso", 32'h0);
    if (n > 0) expect_rd("rd_word", first);
    for (int k = 1; k < n; k++) expect_rd("rd_word", m_pop());
    if (n > 0) void'(m_pop());
    frame_start();
    xfer(32'h02, 8, push_cmd ? 0 : -1, pd, q);
    obs_rd.push_back(q);
    for (int k = 0; k < n; k++) begin
      xfer(32'h0, 32, -1, 0, q);
      obs_rd.push_back(q);
    end
    frame_end();
  endtask

  task automatic status_frame();
    logic [31:0] q;
    int sz;
    sz = mq.size();
    expect_rd("status", {24'h0, m_done, m_ovf, 2'b00, (sz > 15) ? 4'hF : 4'(sz)});
    m_done = 0;
    m_ovf = 0;
    frame_start();
    xfer(32'h03, 8, -1, 0, q);
    xfer(32'h0, 8, -1, 0, q);
    obs_rd.push_back(q);
    frame_end();
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] w;
    int op;
    core.res_valid = 1'b0;
    core.res_data = '0;
    core.matmul_done = 1'b0;

    hold(4);
    check("rst_miso", 32'(miso), 0);
    check("rst_wr_valid", 32'(core.wr_valid), 0);
    check("rst_wr_data", core.wr_data, 0);
    check("rst_res_avail", 32'(core.res_avail), 0);
    rst = 1'b0;
    hold(4);

    write_frame(2, 32'hDEADBEEF, 32'h01234567);
    check("wr_data_held", core.wr_data, 32'h01234567);

    core_push(32'hAAAA0001);
    core_push(32'hAAAA0002);
    core_push(32'hAAAA0003);
    check("res_avail_full", 32'(core.res_avail), 1);
    read_frame(3, 0, 0);
    check("res_avail_drained", 32'(core.res_avail), 0);

    for (int k = 0; k < 5; k++) core_push(32'hBB000000 + 32'(k));
    core_done();
    status_frame();
    status_frame();
    read_frame(4, 0, 0);

    read_frame(2, 0, 0);
    status_frame();

    frame_start();
    xfer(32'h01, 8, -1, 0, q);
    xfer($urandom, 20, -1, 0, q);
    frame_end();
    write_frame(1, 32'hCAFEF00D, 0);

    core_push(32'h11110000);
    core_push(32'h22220000);
    frame_start();
    xfer(32'h02, 8, -1, 0, q);
    xfer(32'h0, 10, -1, 0, q);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    mq.delete();
    m_done = 0;
    m_ovf = 0;
    check("midrst_res_avail", 32'(core.res_avail), 0);
    check("midrst_wr_data", core.wr_data, 0);
    check("midrst_miso", 32'(miso), 0);
    xfer(32'h01, 8, -1, 0, q);
    xfer(32'h55AA55AA, 32, -1, 0, q);
    frame_end();
    core_push(32'h33330000);
    read_frame(1, 0, 0);

    for (int k = 0; k < 4; k++) core_push(32'hC0DE0000 + 32'(k));
    read_frame(0, 1, 32'hC0DE00FF);
    status_frame();
    read_frame(4, 0, 0);

    frame_start();
    xfer(32'h04, 8, -1, 0, q);
    xfer(32'h5A, 8, -1, 0, q);
`ifdef SPI_BRIDGE_ECHO_EN
    expect_rd("echo0", 32'h00);
    obs_rd.push_back(q);
    xfer(32'h3C, 8, -1, 0, q);
    expect_rd("echo1", 32'h5A);
    obs_rd.push_back(q);
`else
    expect_rd("ignore0", 32'h00);
    obs_rd.push_back(q);
    xfer(32'h3C, 8, -1, 0, q);
    expect_rd("ignore1", 32'h00);
    obs_rd.push_back(q);
`endif
    frame_end();
    status_frame();

    for (int it = 0; it < 20; it++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: write_frame(int'($urandom_range(1, 2)), $urandom, $urandom);
        1: begin
          for (int k = int'($urandom_range(1, 3)); k > 0; k--) core_push($urandom);
        end
        2: read_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom);
        3: status_frame();
        default: core_done();
      endcase
    end
    status_frame();

    hold(20);
    check("wr_pending", 32'(exp_wr.size()), 0);
    check("rd_pending", 32'(exp_rd.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
